// File: rtl/fd_insn_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fd_insn_buffer
//  Brief    : Two-entry fetch/decode skid buffer holding {pc, insn} pairs,
//             with valid/ready handshake, branch flush and decode-field split.
//  Revision : 1.0 - initial release
// ============================================================================
module fd_insn_buffer #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_INSN = 32'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [31:0]         in_insn,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_insn,
  output logic [4:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [16:0]         out_imm17,
  output logic [26:0]         out_tgt27,
  output logic [1:0]          count
);

  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_one   = 2'd1;
  localparam logic [1:0] c_full  = 2'd2;

  logic [PC_WIDTH-1:0] r_head_pc;
  logic [31:0]         r_head_insn;
  logic [PC_WIDTH-1:0] r_tail_pc;
  logic [31:0]         r_tail_insn;
  logic [1:0]          r_count;

  logic w_push;
  logic w_pop;

  // Handshake qualifiers; in_ready comes only from registered occupancy so
  // there is no combinational path from decode back to fetch.
  always_comb begin
    in_ready  = (r_count != c_full);
    out_valid = (r_count != c_empty);
    w_push    = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready;
  end

  // Occupancy and entry storage; head always holds the oldest entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= c_empty;
      r_head_pc   <= '0;
      r_head_insn <= NOP_INSN;
      r_tail_pc   <= '0;
      r_tail_insn <= NOP_INSN;
    end else if (flush) begin
      // Stored data is left as-is: it is masked at the outputs once empty.
      r_count <= c_empty;
    end else begin
      case (r_count)
        c_empty: begin
          if (w_push) begin
            r_head_pc   <= in_pc;
            r_head_insn <= in_insn;
            r_count     <= c_one;
          end
        end
        c_one: begin
          if (w_push && !w_pop) begin
            r_tail_pc   <= in_pc;
            r_tail_insn <= in_insn;
            r_count     <= c_full;
          end else if (w_push && w_pop) begin
            r_head_pc   <= in_pc;
            r_head_insn <= in_insn;
          end else if (w_pop) begin
            r_count <= c_empty;
          end
        end
        c_full: begin
          // in_ready is low here, so only a pop can occur.
          if (w_pop) begin
            r_head_pc   <= r_tail_pc;
            r_head_insn <= r_tail_insn;
            r_count     <= c_one;
          end
        end
        default: r_count <= c_empty;
      endcase
    end
  end

  // Head presentation; an empty buffer shows a NOP at pc 0 so downstream
  // field decode and sign extension see benign values.
  always_comb begin
    count      = r_count;
    out_pc     = out_valid ? r_head_pc   : '0;
    out_insn   = out_valid ? r_head_insn : NOP_INSN;
    out_opcode = out_insn[31:27];
    out_rd     = out_insn[26:22];
    out_rs     = out_insn[21:17];
    out_rt     = out_insn[16:12];
    out_imm17  = out_insn[16:0];
    out_tgt27  = out_insn[26:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_fd_insn_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_insn_buffer
//  Brief    : Self-checking bench for fd_insn_buffer against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fd_insn_buffer;

  localparam int          c_pw  = 32;
  localparam logic [31:0] c_nop = 32'h0;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [c_pw-1:0] in_pc;
  logic [31:0]     in_insn;
  logic            flush;
  logic            out_ready;
  logic            out_valid;
  logic [c_pw-1:0] out_pc;
  logic [31:0]     out_insn;
  logic [4:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [16:0]     out_imm17;
  logic [26:0]     out_tgt27;
  logic [1:0]      count;

  fd_insn_buffer #(.PC_WIDTH(c_pw), .NOP_INSN(c_nop)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_insn(out_insn), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_imm17(out_imm17), .out_tgt27(out_tgt27), .count(count)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  typedef struct packed {
    logic [c_pw-1:0] pc;
    logic [31:0]     insn;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model queue.
  task automatic check_state(input string tag);
    logic [c_pw-1:0] epc;
    logic [31:0]     ein;
    epc = '0;
    ein = c_nop;
    if (q.size() != 0) begin
      epc = q[0].pc;
      ein = q[0].insn;
    end
    chk({tag, ".count"},     64'(count),     64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    chk({tag, ".out_pc"},    64'(out_pc),    64'(epc));
    chk({tag, ".out_insn"},  64'(out_insn),  64'(ein));
    chk({tag, ".fields"},
        {out_opcode, out_rd, out_rs, out_rt, out_imm17, out_tgt27},
        {ein[31:27], ein[26:22], ein[21:17], ein[16:12], ein[16:0], ein[26:0]});
  endtask

  // One clock of stimulus: drive at negedge, check, then advance the model.
  task automatic step(input logic rst, input logic iv, input logic [c_pw-1:0] pc,
                      input logic [31:0] insn, input logic fl, input logic ordy,
                      input string tag);
    int   pre;
    ent_t e;
    @(negedge clock);
    reset     = rst;
    in_valid  = iv;
    in_pc     = pc;
    in_insn   = insn;
    flush     = fl;
    out_ready = ordy;
    #1;
    check_state(tag);
    pre = q.size();
    if (rst || fl) begin
      q.delete();
    end else begin
      if (pre != 0 && ordy) void'(q.pop_front());
      if (iv && pre < 2) begin
        e.pc   = pc;
        e.insn = insn;
        q.push_back(e);
      end
    end
    @(posedge clock);
  endtask

  initial begin
    logic [c_pw-1:0] pc_ctr;
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_insn = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    q.delete();

    // Reset state.
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, "rst");
    #1;
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.imm17", 64'(out_imm17), 64'd0);

    // Single push then drain; check decoded fields explicitly.
    step(1'b0, 1'b1, 32'h10, 32'h2881_FFFF, 1'b0, 1'b1, "t1_push");
    #1;
    chk("t1.out_valid", 64'(out_valid), 64'd1);
    chk("t1.imm17", 64'(out_imm17), 64'h1FFFF);
    chk("t1.rd", 64'(out_rd), 64'd2);
    chk("t1.rs", 64'(out_rs), 64'd0);
    chk("t1.opcode", 64'(out_opcode), 64'd5);
    chk("t1.count", 64'(count), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "t1_pop");
    #1;
    chk("t1.drained", 64'(count), 64'd0);

    // Fill while stalled; third push rejected and re-presented.
    step(1'b0, 1'b1, 32'd4,  32'hA000_0004, 1'b0, 1'b0, "t2_a");
    step(1'b0, 1'b1, 32'd8,  32'hB000_0008, 1'b0, 1'b0, "t2_b");
    #1;
    chk("t2.full_count", 64'(count), 64'd2);
    chk("t2.full_ready", 64'(in_ready), 64'd0);
    step(1'b0, 1'b1, 32'd12, 32'hC000_000C, 1'b0, 1'b0, "t2_c_rej");
    step(1'b0, 1'b1, 32'd12, 32'hC000_000C, 1'b0, 1'b1, "t2_pop_a");
    step(1'b0, 1'b1, 32'd12, 32'hC000_000C, 1'b0, 1'b1, "t2_pop_b");
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "t2_pop_c");
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "t2_empty");

    // Simultaneous push and pop at count 1.
    step(1'b0, 1'b1, 32'h20, 32'h1111_0020, 1'b0, 1'b0, "t3_a");
    step(1'b0, 1'b1, 32'h24, 32'h2222_0024, 1'b0, 1'b1, "t3_ab");
    #1;
    chk("t3.head_b", 64'(out_pc), 64'h24);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "t3_pop_b");

    // Flush while full with push and pop in the same cycle.
    step(1'b0, 1'b1, 32'h30, 32'h3333_0030, 1'b0, 1'b0, "t4_a");
    step(1'b0, 1'b1, 32'h34, 32'h3434_0034, 1'b0, 1'b0, "t4_b");
    step(1'b0, 1'b1, 32'h38, 32'h3838_0038, 1'b1, 1'b1, "t4_flush");
    #1;
    chk("t4.out_valid", 64'(out_valid), 64'd0);
    chk("t4.out_pc", 64'(out_pc), 64'd0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "t4_after");

    // Reset with flush and push while full.
    step(1'b0, 1'b1, 32'h40, 32'h4040_0040, 1'b0, 1'b0, "t5_a");
    step(1'b0, 1'b1, 32'h44, 32'h4444_0044, 1'b0, 1'b0, "t5_b");
    step(1'b1, 1'b1, 32'h48, 32'h4848_0048, 1'b1, 1'b1, "t5_rst");
    #1;
    chk("t5.in_ready", 64'(in_ready), 64'd1);
    chk("t5.count", 64'(count), 64'd0);

    // Randomized traffic against the queue model.
    pc_ctr = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      logic r, v, f, o;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      step(r, v, pc_ctr, $urandom, f, o, "rnd");
      pc_ctr = pc_ctr + 32'd4;
    end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
